// File: rtl/alu_cmd_sequencer_if.sv
// Trigger/switch inputs and command outputs between the board controls and the ALU command sequencer.
// master = sequencer side, slave = board/ALU side.
interface alu_cmd_sequencer_if;
  logic       btn_raw;
  logic [3:0] op_in;
  logic [7:0] data_in;
  logic [3:0] op_q;
  logic [7:0] data_q;
  logic       load_a;
  logic       load_b;
  logic       swap;
  logic       exec;
  logic       busy;
  logic [7:0] cmd_count;

  modport master (
    input  btn_raw, op_in, data_in,
    output op_q, data_q, load_a, load_b, swap, exec, busy, cmd_count
  );

  modport slave (
    output btn_raw, op_in, data_in,
    input  op_q, data_q, load_a, load_b, swap, exec, busy, cmd_count
  );
endinterface

// File: rtl/alu_cmd_sequencer.sv
// Button conditioning and one-pulse-per-press command sequencer for the board ALU.
// Define AUTO_REPEAT_EN to refire periodically while the button stays held.
module alu_cmd_sequencer #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned REPEAT_CYCLES   = 50000000
) (
  input logic                 clk,
  input logic                 reset,
  alu_cmd_sequencer_if.master bus
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  if (DEBOUNCE_CYCLES < 2 || REPEAT_CYCLES < 1) begin : g_param_check
    $error("alu_cmd_sequencer: DEBOUNCE_CYCLES must be >= 2 and REPEAT_CYCLES >= 1");
  end

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_DB     = 2'd1,
    FIRE         = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_t;

  state_t           state;
  logic             meta;
  logic             sync;
  logic [CNT_W-1:0] cnt;
  logic             fire_c;
  logic             rpt_fire_c;
  logic             dec_load_a_c;
  logic             dec_load_b_c;
  logic             dec_swap_c;
  logic             dec_exec_c;

  // Two-flop synchroniser on the raw button
  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= 1'b0;
      sync <= 1'b0;
    end else begin
      meta <= bus.btn_raw;
      sync <= meta;
    end
  end

  // Op decode; only ever sampled on the edge that enters FIRE
  always_comb begin
    dec_load_a_c = (bus.op_in == 4'b1111);
    dec_load_b_c = (bus.op_in == 4'b1101);
    dec_swap_c   = (bus.op_in == 4'b1110);
    dec_exec_c   = ~(dec_load_a_c | dec_load_b_c | dec_swap_c);
  end

`ifdef AUTO_REPEAT_EN
  localparam int unsigned RPT_W = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
  localparam logic [RPT_W-1:0] RPT_LAST = RPT_W'(REPEAT_CYCLES - 1);

  logic [RPT_W-1:0] rpt_cnt;

  // Counting starts in the FIRE cycle so repeat fires land exactly REPEAT_CYCLES apart
  always_ff @(posedge clk) begin
    if (reset || !sync || fire_c) begin
      rpt_cnt <= '0;
    end else if (state == FIRE || state == RELEASE_WAIT) begin
      rpt_cnt <= rpt_cnt + RPT_W'(1);
    end
  end

  assign rpt_fire_c = (state == RELEASE_WAIT) && sync && (rpt_cnt == RPT_LAST);
`else
  assign rpt_fire_c = 1'b0;
`endif

  assign fire_c = ((state == PRESS_DB) && sync && (cnt == CNT_LAST)) || rpt_fire_c;

  // Sequencer FSM with registered capture, pulses, busy and fire count
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      cnt           <= '0;
      bus.busy      <= 1'b0;
      bus.op_q      <= '0;
      bus.data_q    <= '0;
      bus.load_a    <= 1'b0;
      bus.load_b    <= 1'b0;
      bus.swap      <= 1'b0;
      bus.exec      <= 1'b0;
      bus.cmd_count <= '0;
    end else begin
      bus.load_a <= 1'b0;
      bus.load_b <= 1'b0;
      bus.swap   <= 1'b0;
      bus.exec   <= 1'b0;

      if (fire_c) begin
        bus.op_q      <= bus.op_in;
        bus.data_q    <= bus.data_in;
        bus.load_a    <= dec_load_a_c;
        bus.load_b    <= dec_load_b_c;
        bus.swap      <= dec_swap_c;
        bus.exec      <= dec_exec_c;
        bus.cmd_count <= bus.cmd_count + 8'd1;
      end

      case (state)
        IDLE: begin
          if (sync) begin
            state    <= PRESS_DB;
            cnt      <= '0;
            bus.busy <= 1'b1;
          end
        end
        PRESS_DB: begin
          if (!sync) begin
            state    <= IDLE;
            cnt      <= '0;
            bus.busy <= 1'b0;
          end else if (fire_c) begin
            state <= FIRE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        FIRE: begin
          state <= RELEASE_WAIT;
          cnt   <= '0;
        end
        RELEASE_WAIT: begin
          if (fire_c) begin
            state <= FIRE;
            cnt   <= '0;
          end else if (sync) begin
            cnt <= '0;
          end else if (cnt == CNT_LAST) begin
            state    <= IDLE;
            cnt      <= '0;
            bus.busy <= 1'b0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          state    <= IDLE;
          cnt      <= '0;
          bus.busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/alu_cmd_sequencer.md
Name: alu_cmd_sequencer

Overview:
Upstream control stage for the board-level ALU. It conditions the raw trigger button (synchroniser, debounce, release detection) and turns each accepted press into exactly one single-cycle command pulse. The pulse is load_a, load_b, swap or exec, decoded from the op switches. The op and data switches are captured at the instant of acceptance, so the register file and ALU see stable values and one action per press instead of level-driven loads.

Parameters:
DEBOUNCE_CYCLES, 1000000, consecutive clk cycles the synchronised button must be stable to accept a press or a release (10 ms at 100 MHz); minimum 2.
REPEAT_CYCLES, 50000000, hold interval between auto-repeat fires; used only with AUTO_REPEAT_EN.

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
btn_raw  input  1  asynchronous raw trigger button (btnU)
op_in  input  4  operation switches (sw[3:0])
data_in  input  8  data switches (sw[15:8])
op_q  output  4  op captured at last fire
data_q  output  8  data captured at last fire
load_a  output  1  one-cycle pulse, op 1111
load_b  output  1  one-cycle pulse, op 1101
swap  output  1  one-cycle pulse, op 1110
exec  output  1  one-cycle pulse, any other op (ALU trigger)
busy  output  1  high in every state except IDLE
cmd_count  output  8  number of fires, wraps modulo 256

Behaviour:
- Synchroniser: two flops on btn_raw; sync = second flop. Reset clears both to 0.
- Debounce counter: width $clog2(DEBOUNCE_CYCLES); cleared on every state change and whenever sync disagrees with the level being qualified.
- IDLE:
  - sync=1 -> PRESS_DB, cnt=0.
- PRESS_DB:
  - sync=0 -> IDLE (bounce rejected, no pulse).
  - sync=1 and cnt==DEBOUNCE_CYCLES-1 -> FIRE.
  - otherwise cnt+1.
- FIRE: lasts exactly one cycle, then -> RELEASE_WAIT.
- RELEASE_WAIT:
  - sync=1 -> stay, cnt=0.
  - sync=0 -> count; cnt==DEBOUNCE_CYCLES-1 -> IDLE.
- Capture and pulse timing:
  - On the edge entering FIRE, op_q<=op_in and data_q<=data_in, sampled on that edge.
  - On that same edge exactly one pulse register is set from op_in; it clears on the next edge. Pulses are registered outputs with no combinational path from inputs.
  - Decode: 1111 load_a; 1101 load_b; 1110 swap; all 13 other codes exec.
- Latency: let edge N be the first edge at which btn_raw is sampled high, held stable. The pulse is high for the cycle following edge N+2+DEBOUNCE_CYCLES.
- cmd_count increments on the edge entering FIRE; 255 -> 0 wraps silently.
- At most one fire per press. A second press is not accepted until a full release debounce completes.
- Bounce during RELEASE_WAIT restarts the release count and never generates a pulse.
- Switch changes outside the FIRE edge have no effect on op_q/data_q or on the pulses.
- Reset (any state, including the FIRE cycle):
  - Next edge gives state IDLE, cnt=0, all pulses 0, busy=0, op_q=0, data_q=0, cmd_count=0, synchroniser 0.
  - A button still held after reset is treated as a fresh press and fires after full debounce.
- Reset has priority over all other events in the same cycle.

Optional Feature:
AUTO_REPEAT_EN:
- Defined:
  - In RELEASE_WAIT, a separate repeat counter counts cycles with sync=1, cleared whenever sync=0.
  - When it reaches REPEAT_CYCLES-1 the block re-enters FIRE: re-samples op_in/data_in, emits one pulse, increments cmd_count and clears the repeat counter.
  - Repeat applies to all ops.
- Undefined: no repeat counter is instantiated, REPEAT_CYCLES is ignored, and holding the button never refires.

Test Plan:
(All scenarios use DEBOUNCE_CYCLES=4, REPEAT_CYCLES=20.)
- Clean press, op_in=0011, data_in=0x5A, btn held 30 cycles then released:
  - exec high for exactly 1 cycle, following edge N+6.
  - op_q=0011, data_q=0x5A, cmd_count=1, no other pulse.
  - busy falls 4 cycles after sync falls.
- Op decode: four clean presses with op_in=1111, 1101, 1110, 0000 -> load_a, load_b, swap, exec respectively, one pulse each; cmd_count=4.
- Bounce rejection: btn high 2 cycles, low 1, high 2, low -> no pulse, state returns to IDLE, cmd_count=0.
- Release bounce: after fire, btn low 2, high 1, low 10 cycles -> no second pulse; IDLE reached 4 cycles after the final low is synchronised.
- Wrap and reset mid-operation:
  - 256 clean presses -> cmd_count=0.
  - Then assert reset during PRESS_DB -> no pulse, all outputs 0.
  - With btn still held after reset deasserts -> one exec pulse after full debounce.
- With AUTO_REPEAT_EN, btn held 70 cycles after first fire -> exactly 3 additional pulses spaced 20 cycles apart; cmd_count=4.
